sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set SRAM access cycles per transfer (legal 1..7).
REQ-002 Parameter ADDR_W, default 20, SHALL set SRAM word-address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-low reset.
REQ-005 if_ce_i  in  1  instruction-fetch request; if_addr_i  in  32  fetch byte address.
REQ-006 if_data_o  out  32  fetched word; if_ready_o  out  1  one-cycle completion pulse for fetch.
REQ-007 mem_ce_i  in  1  data request; mem_we_i  in  1  1=write; mem_addr_i  in  32  byte address; mem_data_i  in  32  write data.
REQ-008 mem_data_o  out  32  read word; mem_ready_o  out  1  one-cycle completion pulse for data.
REQ-009 stallreq_o  out  1  pipeline stall request to ctrl.
REQ-010 sram_addr_o  out  ADDR_W  word address; sram_dq_i  in  32; sram_dq_o  out  32; sram_dq_oe_o  out  1.
REQ-011 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low SRAM strobes.

Function
REQ-012 Word address SHALL be addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-013 FSM states SHALL be IDLE, SETUP, ACCESS, DONE.
REQ-014 IDLE: if mem_ce_i, grant data port; else if if_ce_i, grant fetch port; else stay; grant, address, we, write data latched on IDLE->SETUP.
REQ-015 Priority SHALL be fixed: data port over fetch port when both request in IDLE.
REQ-016 SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1; dq_oe=1 and dq_o=write data for writes.
REQ-017 ACCESS (WAIT_CYCLES cycles, 3-bit down-counter): reads oe_n=0; writes we_n=0, dq_oe=1.
REQ-018 Read data SHALL be registered from sram_dq_i on last ACCESS cycle into granted port's data output.
REQ-019 DONE (1 cycle): all strobes high, dq_oe=0, address held, granted port's ready=1; then IDLE.
REQ-020 Grant-to-ready latency SHALL be WAIT_CYCLES+2 cycles from SETUP entry; one IDLE cycle between transfers.
REQ-021 Requesters SHALL hold ce and inputs until ready; a request dropped mid-transfer still completes and pulses ready.
REQ-022 stallreq_o SHALL equal (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o), combinational.
REQ-023 if_data_o/mem_data_o SHALL hold last value until overwritten by a later read to that port.
REQ-024 A write SHALL never update if_data_o or mem_data_o.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE, counter 0, grant cleared, from any state including mid-ACCESS.
REQ-026 Reset outputs: strobes 1, dq_oe 0, sram_addr_o 0, sram_dq_o 0, ready 0, data outputs 0.

Configuration
REQ-027 Macro SRAM_ARB_IBUF_EN defined: one-entry fetch buffer (valid, word tag, data) SHALL be compiled in.
REQ-028 With it: in IDLE, fetch with no data request and tag hit SHALL skip SRAM, pulse if_ready_o next cycle with buffered data.
REQ-029 With it: every SRAM fetch fills buffer; any data write to same word address clears valid; reset clears valid.
REQ-030 Without macro: every fetch SHALL use full SRAM sequence; no buffer state exists.

Structure
REQ-031 Shared package sram_arb_pkg SHALL hold state encoding, grant encoding (GNT_IF, GNT_MEM), counter width.
REQ-032 Sub-module sram_arb_ibuf SHALL implement the fetch buffer, instantiated only under SRAM_ARB_IBUF_EN.

Verification
REQ-033 Fetch 0x00000010, dq_i=0x3C011234, WAIT_CYCLES=1 -> sram_addr_o=0x4, oe_n low 1 cycle, if_ready_o at cycle 3, if_data_o=0x3C011234.
REQ-034 Write 0x00000020 data 0xDEADBEEF -> sram_addr_o=0x8, dq_o=0xDEADBEEF, we_n low WAIT_CYCLES cycles, mem_ready_o pulse, stallreq_o high until pulse.
REQ-035 if_ce_i and mem_ce_i (read 0x40) same cycle -> data served first, fetch granted after one IDLE cycle, two ready pulses in order.
REQ-036 rst=0 during ACCESS of a write -> next cycle strobes high, dq_oe 0, no ready pulse; resume on rst=1.
REQ-037 SRAM_ARB_IBUF_EN: fetch 0x10 twice -> second ready one cycle after request, no ce_n activity; write 0x10 then fetch 0x10 -> full SRAM access.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM arbiter: FSM states, port grant and the
// width of the access-cycle down-counter.
package sram_arb_pkg;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF  = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

endpackage

// File: rtl/sram_arb_ibuf.sv
// One-entry instruction-fetch buffer (valid, word tag, data) for sram_arbiter;
// only instantiated when SRAM_ARB_IBUF_EN is defined.
module sram_arb_ibuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_tag_i,
  output logic              hit_o,
  output logic [31:0]       data_o,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_tag_i,
  input  logic [31:0]       fill_data_i,
  input  logic              inval_i,
  input  logic [ADDR_W-1:0] inval_tag_i
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [31:0]       data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      data_d  = fill_data_i;
    end else if (inval_i && (inval_tag_i == tag_q)) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) valid_q <= 1'b0;
    else      valid_q <= valid_d;
  end

  // NOTE: tag and data need no reset; valid_q alone decides whether they are looked at.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign hit_o  = valid_q && (tag_q == lookup_tag_i);
  assign data_o = data_q;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a fetch port and a data port onto one asynchronous SRAM.
// Define SRAM_ARB_IBUF_EN to add a one-entry fetch buffer in front of the SRAM.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ready_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  gnt_e              gnt_q, gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_data_q, mem_data_d;

  logic [ADDR_W-1:0] if_word, mem_word;
  logic              ibuf_hit;
  logic [31:0]       ibuf_data;
  logic              unused_addr_bits;

  assign if_word  = if_addr_i[ADDR_W+1:2];
  assign mem_word = mem_addr_i[ADDR_W+1:2];
  assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                              mem_addr_i[31:ADDR_W+2], mem_addr_i[1:0]};

`ifdef SRAM_ARB_IBUF_EN
  logic ibuf_fill, ibuf_inval;

  assign ibuf_fill  = (state_q == ST_ACCESS) && (cnt_q == '0) && !we_q && (gnt_q == GNT_IF);
  assign ibuf_inval = (state_q == ST_IDLE) && mem_ce_i && mem_we_i;

  sram_arb_ibuf #(.ADDR_W(ADDR_W)) u_ibuf (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag_i (if_word),
    .hit_o        (ibuf_hit),
    .data_o       (ibuf_data),
    .fill_i       (ibuf_fill),
    .fill_tag_i   (addr_q),
    .fill_data_i  (sram_dq_i),
    .inval_i      (ibuf_inval),
    .inval_tag_i  (mem_word)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_data_d    = if_data_q;
    mem_data_d   = mem_data_q;
    sram_ce_n_o  = 1'b1;
    sram_oe_n_o  = 1'b1;
    sram_we_n_o  = 1'b1;
    sram_dq_oe_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          gnt_d   = GNT_MEM;
          addr_d  = mem_word;
          we_d    = mem_we_i;
          wdata_d = mem_data_i;
          state_d = ST_SETUP;
        end else if (if_ce_i) begin
          gnt_d = GNT_IF;
          we_d  = 1'b0;
          if (ibuf_hit) begin
            // Buffered fetch: no SRAM cycle, answer on the next clock.
            if_data_d = ibuf_data;
            state_d   = ST_DONE;
          end else begin
            addr_d  = if_word;
            state_d = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        sram_ce_n_o  = 1'b0;
        sram_dq_oe_o = we_q;
        cnt_d        = CNT_W'(WAIT_CYCLES - 1);
        state_d      = ST_ACCESS;
      end
      ST_ACCESS: begin
        sram_ce_n_o  = 1'b0;
        sram_oe_n_o  = we_q;
        sram_we_n_o  = !we_q;
        sram_dq_oe_o = we_q;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          if (!we_q) begin
            if (gnt_q == GNT_IF) if_data_d  = sram_dq_i;
            else                 mem_data_d = sram_dq_i;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      gnt_q      <= GNT_IF;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign if_ready_o  = (state_q == ST_DONE) && (gnt_q == GNT_IF);
  assign mem_ready_o = (state_q == ST_DONE) && (gnt_q == GNT_MEM);
  assign if_data_o   = if_data_q;
  assign mem_data_o  = mem_data_q;
  assign sram_addr_o = addr_q;
  assign sram_dq_o   = wdata_q;
  assign stallreq_o  = (if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o);

endmodule
